// File: rtl/count_capture_fifo.sv
// Show-ahead FIFO that samples a live count on a capture strobe and flags dropped samples.
// Optional build macro COUNT_CAPTURE_DELTA_EN stores the difference from the previous capture instead of the raw count.
module count_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       capture,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_nxt;
    logic             vld_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_nxt;
    logic             ovf_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sample;

    function automatic logic [WIDTH-1:0] delta_of(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] prev);
        return cur - prev;
    endfunction

`ifdef COUNT_CAPTURE_DELTA_EN
    logic [WIDTH-1:0] prev_cap;

    // prev_cap follows every strobe, even dropped ones, so deltas stay strobe-to-strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_cap <= '0;
        end else if (capture) begin
            prev_cap <= count_in;
        end
    end

    assign sample = delta_of(count_in, prev_cap);
`else
    assign sample = count_in;
`endif

    assign pop  = vld_q & out_ready;
    assign push = capture & ((level_q < LW'(DEPTH)) | pop);

    always_comb begin
        level_nxt = level_q;
        case ({push, pop})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Next head: the entry behind the popped one, or the fresh sample when it lands in an
    // empty (or just-emptied) FIFO; otherwise hold, which keeps the last popped value when empty.
    always_comb begin
        head_nxt = head_q;
        if (pop) begin
            if (level_q > LW'(1)) begin
                head_nxt = mem[rd_ptr + PW'(1)];
            end else if (push) begin
                head_nxt = sample;
            end
        end else if ((level_q == '0) && push) begin
            head_nxt = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            vld_q   <= 1'b0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_nxt;
            vld_q   <= (level_nxt != '0);
            head_q  <= head_nxt;
            if (capture && !push) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_data  = head_q;
    assign out_valid = vld_q;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Self-checking bench for count_capture_fifo: queue-based reference model compared every cycle
// plus directed scenarios with literal expectations (raw and COUNT_CAPTURE_DELTA_EN builds).
module tb_count_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] count_in;
    logic             capture;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             clr_ovf;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_in  (count_in),
        .capture   (capture),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored samples plus the last value that left the FIFO.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last = '0;
    logic [WIDTH-1:0] m_prev = '0;
    bit               m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_last = '0;
            m_prev = '0;
            m_ovf  = 1'b0;
        end else begin
            bit               do_pop;
            bit               do_push;
            logic [WIDTH-1:0] val;
            do_pop  = (mq.size() != 0) && out_ready;
            do_push = capture && ((mq.size() < DEPTH) || do_pop);
`ifdef COUNT_CAPTURE_DELTA_EN
            val = count_in - m_prev;
`else
            val = count_in;
`endif
            if (do_pop) m_last = mq.pop_front();
            if (do_push) mq.push_back(val);
            if (capture && !do_push) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (capture) m_prev = count_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_valid", out_valid, (mq.size() != 0));
            check("cmp_level", level, mq.size());
            check("cmp_data", out_data, (mq.size() != 0) ? mq[0] : m_last);
            check("cmp_ovf", overflow, m_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [WIDTH-1:0] c);
        count_in = c;
        capture  = 1'b1;
        step();
        capture  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain_expect(input string name, input logic [WIDTH-1:0] exp);
        check({name, "_vld"}, out_valid, 1'b1);
        check(name, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

`ifdef COUNT_CAPTURE_DELTA_EN
    localparam logic [WIDTH-1:0] F1 = 8'd1, F2 = 8'd1, F3 = 8'd1, F4 = 8'd1, F9 = 8'd5;
    localparam logic [WIDTH-1:0] D1 = 8'd5, D2 = 8'd7, D3 = 8'hF7;
`else
    localparam logic [WIDTH-1:0] F1 = 8'd1, F2 = 8'd2, F3 = 8'd3, F4 = 8'd4, F9 = 8'd9;
    localparam logic [WIDTH-1:0] D1 = 8'd5, D2 = 8'd12, D3 = 8'd3;
`endif

    initial begin
        rst_n     = 1'b0;
        capture   = 1'b1;
        count_in  = 8'h77;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset held two cycles with capture active
        step();
        chk_en = 1'b1;
        step();
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        capture = 1'b0;
        rst_n   = 1'b1;
        step();

        // Single sample, held while not ready, then popped
        cap(8'h2A);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'h2A);
        check("single_level", level, 1);
        step();
        check("single_hold", out_data, 8'h2A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_pop_level", level, 0);
        check("single_pop_valid", out_valid, 0);
        // Pop while empty is ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_level", level, 0);

        // Fill and overflow; the dropping capture also carries clr_ovf (set wins)
        do_reset();
        for (int i = 1; i <= 4; i++) cap(WIDTH'(i));
        clr_ovf = 1'b1;
        cap(8'd5);
        clr_ovf = 1'b0;
        check("fill_level", level, 4);
        check("fill_ovf", overflow, 1);
        drain_expect("fill_d0", F1);
        drain_expect("fill_d1", F2);
        drain_expect("fill_d2", F3);
        drain_expect("fill_d3", F4);
        check("fill_empty", out_valid, 0);
        check("fill_last", out_data, F4);
        check("fill_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_ovf", overflow, 0);

        // Push and pop together while full
        do_reset();
        for (int i = 1; i <= 4; i++) cap(WIDTH'(i));
        out_ready = 1'b1;
        cap(8'd9);
        out_ready = 1'b0;
        check("full_pp_level", level, 4);
        check("full_pp_ovf", overflow, 0);
        drain_expect("full_pp_d0", F2);
        drain_expect("full_pp_d1", F3);
        drain_expect("full_pp_d2", F4);
        drain_expect("full_pp_d3", F9);

        // Reset mid-stream flushes all entries
        do_reset();
        for (int i = 0; i < 3; i++) cap(WIDTH'(8'h20 + i));
        check("mid_level3", level, 3);
        do_reset();
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        cap(8'h10);
        check("mid_one_level", level, 1);
        drain_expect("mid_only", 8'h10);
        check("mid_after", level, 0);

        // Wrapping delta sequence
        do_reset();
        cap(8'd5);
        cap(8'd12);
        cap(8'd3);
        drain_expect("seq_d0", D1);
        drain_expect("seq_d1", D2);
        drain_expect("seq_d2", D3);

        // Mixed traffic, checked by the model every cycle
        do_reset();
        for (int i = 0; i < 120; i++) begin
            count_in  = WIDTH'(i * 7 + 3);
            capture   = (i % 3) != 0;
            out_ready = (i % 5) < 2;
            clr_ovf   = (i % 11) == 0;
            rst_n     = (i != 77);
            step();
        end
        capture   = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        rst_n     = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
